// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
// ----------------
// Write-side producer for the register file. Pipeline write-back requests
// are accepted over a valid/ready handshake and held in an in-order FIFO.
// The oldest entry is offered on the register file's single write port
// whenever that port is available. Values that are queued but not yet
// committed can be forwarded to two read lookups. A per-register pending
// mask is provided for hazard detection.
//
// Ports
//   clk          rising-edge clock
//   reset_n      synchronous reset, ACTIVE HIGH (1 = reset)
//   in_valid     write-back request present
//   in_ready     queue can accept a request (from registered state only)
//   in_reg       destination register of the request
//   in_data      value to write
//   drain_en     register file write port available this cycle
//   ctrlRegWrite write strobe to the register file
//   writeReg     write address (0 when the queue is empty)
//   writeData    write data (0 when the queue is empty)
//   lk1_reg/lk2_reg    forwarding lookup addresses
//   lk1_hit/lk2_hit    lookup matches a queued entry
//   lk1_data/lk2_data  youngest queued value for the lookup (0 on miss)
//   pending      bit r set iff a queued entry targets register r
//   count        number of queued entries
module regfile_wb_queue #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS  = 4,
  parameter int REG_AW    = 2,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_AW-1:0]        in_reg,
  input  logic [WORD_SIZE-1:0]     in_data,
  input  logic                     drain_en,
  output logic                     ctrlRegWrite,
  output logic [REG_AW-1:0]        writeReg,
  output logic [WORD_SIZE-1:0]     writeData,
  input  logic [REG_AW-1:0]        lk1_reg,
  output logic                     lk1_hit,
  output logic [WORD_SIZE-1:0]     lk1_data,
  input  logic [REG_AW-1:0]        lk2_reg,
  output logic                     lk2_hit,
  output logic [WORD_SIZE-1:0]     lk2_data,
  output logic [NUM_REGS-1:0]      pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [REG_AW-1:0]    entry_reg_r   [DEPTH];
  logic [WORD_SIZE-1:0] entry_data_r  [DEPTH];
  logic [DEPTH-1:0]     entry_valid_r;
  logic [PW-1:0]        head_r;
  logic [PW-1:0]        tail_r;
  logic [PW:0]          count_r;

  logic                 push_s;
  logic                 pop_s;
  logic                 not_empty_s;
  logic [NUM_REGS-1:0]  pending_s;

  // Walk the queue from oldest to youngest so a later match overrides an
  // earlier one; the result is {hit, data} with data 0 on a miss.
  function automatic logic [WORD_SIZE:0] fwd_lookup(input logic [REG_AW-1:0] key);
    logic                 hit;
    logic [WORD_SIZE-1:0] data;
    logic [PW-1:0]        idx;
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_r + i[PW-1:0];
      if (entry_valid_r[idx] && (entry_reg_r[idx] == key)) begin
        hit  = 1'b1;
        data = entry_data_r[idx];
      end else begin
        hit  = hit;
        data = data;
      end
    end
    return {hit, data};
  endfunction

  // in_ready depends only on the registered count, so a full queue refuses
  // a push even when a pop happens on the same edge.
  assign in_ready    = (count_r != FULL_COUNT);
  assign not_empty_s = (count_r != '0);
  assign push_s      = in_valid && in_ready;
  assign pop_s       = not_empty_s && drain_en;

  assign ctrlRegWrite = pop_s;
  assign count        = count_r;
  assign pending      = pending_s;

  assign {lk1_hit, lk1_data} = fwd_lookup(lk1_reg);
  assign {lk2_hit, lk2_data} = fwd_lookup(lk2_reg);

  // Head entry on the write port, forced to zero when nothing is queued.
  always_comb begin
    writeReg  = '0;
    writeData = '0;
    if (not_empty_s) begin
      writeReg  = entry_reg_r[head_r];
      writeData = entry_data_r[head_r];
    end else begin
      writeReg  = '0;
      writeData = '0;
    end
  end

  // One-hot decode of each valid entry's register, ORed together.
  always_comb begin
    pending_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid_r[i]) begin
        pending_s[entry_reg_r[i]] = 1'b1;
      end else begin
        pending_s = pending_s;
      end
    end
  end

  // Pointers, occupancy and valid bits; reset wins over push and pop.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      head_r        <= '0;
      tail_r        <= '0;
      count_r       <= '0;
      entry_valid_r <= '0;
    end else begin
      if (push_s) begin
        tail_r                <= tail_r + 1'b1;
        entry_valid_r[tail_r] <= 1'b1;
      end
      // Head and tail never coincide when both happen (not empty, not full).
      if (pop_s) begin
        head_r                <= head_r + 1'b1;
        entry_valid_r[head_r] <= 1'b0;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload storage, cleared on reset so stale data never leaks out.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg_r[i]  <= '0;
        entry_data_r[i] <= '0;
      end
    end else if (push_s) begin
      entry_reg_r[tail_r]  <= in_reg;
      entry_data_r[tail_r] <= in_data;
    end
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side producer for the 4-entry register file.
- Accepts register write-back requests from the pipeline through a valid/ready handshake and buffers them in an in-order FIFO.
- Drains at most one entry per cycle onto the register file's single write port (ctrlRegWrite/writeReg/writeData).
- Provides read-side forwarding of queued-but-not-yet-committed values, plus per-register pending flags for hazard detection.

Parameters:
- WORD_SIZE, 16, data width; matches the register file word.
- NUM_REGS, 4, number of architectural registers.
- REG_AW, 2, register address width (log2 NUM_REGS).
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-high reset (1 = reset, sampled on rising clk).
- in_valid  input  1  write-back request present.
- in_ready  output  1  queue can accept a request this cycle.
- in_reg  input  REG_AW  destination register of the request.
- in_data  input  WORD_SIZE  value to write.
- drain_en  input  1  register file write port available this cycle.
- ctrlRegWrite  output  1  write strobe to the register file.
- writeReg  output  REG_AW  write address to the register file.
- writeData  output  WORD_SIZE  write data to the register file.
- lk1_reg  input  REG_AW  forwarding lookup 1 address.
- lk1_hit  output  1  lookup 1 matches a queued entry.
- lk1_data  output  WORD_SIZE  newest queued value for lk1_reg; 0 when no hit.
- lk2_reg  input  REG_AW  forwarding lookup 2 address.
- lk2_hit  output  1  lookup 2 matches a queued entry.
- lk2_data  output  WORD_SIZE  newest queued value for lk2_reg; 0 when no hit.
- pending  output  NUM_REGS  bit r = 1 iff any queued entry targets register r.
- count  output  log2(DEPTH)+1  number of queued entries.

Behaviour:
- Storage: circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count register. Each entry holds reg, data and a valid bit.
- Reset (reset_n=1 at a clk edge):
  - head=tail=count=0; all entry valid bits cleared.
  - Consequent outputs: ctrlRegWrite=0, in_ready=1, lk*_hit=0, lk*_data=0, pending=0, writeReg=0, writeData=0.
  - Reset mid-operation discards all queued writes; none reach the register file.
  - Reset has priority over a simultaneous push or pop.
- Push: in_valid && in_ready at a clk edge.
  - Writes {in_reg, in_data} at tail, sets the entry's valid bit, tail+1.
  - in_ready = (count != DEPTH), derived from registered state only; no combinational path from in_valid or drain_en.
  - A full queue refuses a push even when a pop occurs in the same cycle.
- Drain (combinational from head):
  - ctrlRegWrite = (count != 0) && drain_en.
  - writeReg/writeData = head entry when count != 0, else 0.
  - Pop occurs on a clk edge with ctrlRegWrite=1: head+1 and the head entry's valid bit is cleared. The register file commits on the same edge.
  - Latency: a request pushed at edge N is offered no earlier than the cycle after edge N (write committed at edge N+1) when the queue was empty and drain_en=1.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Ordering: strict FIFO. Multiple entries to the same register are all written in order, with no merging.
- Forwarding (combinational):
  - lk*_hit = 1 if any valid entry has reg == lk*_reg.
  - lk*_data = data of the youngest matching entry, i.e. closest to tail, searched in age order from head.
  - The head entry being written this cycle still hits, because the register file updates only at the edge.
  - A request on in_* that is not yet pushed is never forwarded.
- pending: OR over valid entries of a one-hot decode of reg. Updated on the same edges as push/pop.
- Empty (count=0): no write strobe, no hits, pending=0.
- Full (count=DEPTH): in_ready=0; drain continues normally.

Test Plan:
- Reset, then push (r2,0x1234) with drain_en=1 → next cycle ctrlRegWrite=1, writeReg=2, writeData=0x1234; count returns to 0 after that edge; pending=0000.
- drain_en=0; push (r1,0x0011),(r1,0x0022),(r3,0x0033),(r0,0x0044) → count=4, in_ready=0, pending=1011. A fifth push with in_valid=1 is not accepted. lk1_reg=1 → hit, 0x0022; lk2_reg=2 → no hit, data 0.
- From the full state, drain_en=1 for 4 cycles → writes observed in order r1:0x0011, r1:0x0022, r3:0x0033, r0:0x0044; in_ready=1 after the first pop edge; count ends at 0.
- Push every cycle with drain_en=1 continuously for 10 cycles → count stays at 1 after the first edge, one write per cycle, pointer wrap-around exercised with no lost or duplicated entries.
- Queue holding 3 entries, reset_n=1 for one edge coincident with in_valid=1 → count=0, ctrlRegWrite=0, pending=0; no subsequent writes appear.
- Single entry (r3,0xBEEF) at head with drain_en=1 → lk1_reg=3 → hit, 0xBEEF, in the same cycle as ctrlRegWrite=1; after the edge, hit=0 and pending[3]=0.
